// File: rtl/cpu3_pkg.sv
// cpu3_pkg: opcode/combo encodings and execute-stage state type shared by the 3-bit CPU
package cpu3_pkg;
    localparam logic [2:0] OP_ADV = 3'd0;
    localparam logic [2:0] OP_BXL = 3'd1;
    localparam logic [2:0] OP_BST = 3'd2;
    localparam logic [2:0] OP_JNZ = 3'd3;
    localparam logic [2:0] OP_BXC = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;
    localparam logic [2:0] OP_BDV = 3'd6;
    localparam logic [2:0] OP_CDV = 3'd7;
    localparam logic [2:0] COMBO_A   = 3'd4;
    localparam logic [2:0] COMBO_B   = 3'd5;
    localparam logic [2:0] COMBO_C   = 3'd6;
    localparam logic [2:0] COMBO_RSV = 3'd7;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} exec_state_t;
    function automatic logic uses_combo(input logic [2:0] op);
        return !(op == OP_BXL || op == OP_JNZ || op == OP_BXC);
    endfunction
endpackage

// File: rtl/instruction_execute_if.sv
// instruction_execute_if: control, fetch-side and output-stream signals of the execute stage
interface instruction_execute_if #(
    parameter int REG_W = 32
);
    logic             start;
    logic [REG_W-1:0] a_init, b_init, c_init;
    logic [2:0]       opcode, operand;
    logic [3:0]       instr_ptr;
    logic             halt;
    logic             out_valid, out_ready;
    logic [2:0]       out_data;
    logic             busy, done, err;
    logic [REG_W-1:0] reg_a, reg_b, reg_c;
    modport master (
        input  start, a_init, b_init, c_init, opcode, operand, out_ready,
        output instr_ptr, halt, out_valid, out_data, busy, done, err, reg_a, reg_b, reg_c
    );
    modport slave (
        output start, a_init, b_init, c_init, opcode, operand, out_ready,
        input  instr_ptr, halt, out_valid, out_data, busy, done, err, reg_a, reg_b, reg_c
    );
endinterface

// File: rtl/combo_decode.sv
// combo_decode: maps a 3-bit operand to its combo value and flags the reserved encoding
module combo_decode
    import cpu3_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   operand_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] value_o,
    output logic         rsv_o
);
    assign value_o = (operand_i == COMBO_A) ? a_i :
                     (operand_i == COMBO_B) ? b_i :
                     (operand_i == COMBO_C) ? c_i : W'(operand_i);
    assign rsv_o   = operand_i == COMBO_RSV;
endmodule

// File: rtl/instruction_execute.sv
// instruction_execute: execute stage of the 3-bit CPU, sequencing fetch and running the ALU
module instruction_execute
    import cpu3_pkg::*;
#(
    parameter int REG_W    = 32,
    parameter int PROG_LEN = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    instruction_execute_if.master bus
);
    localparam logic [4:0] LAST_IP = 5'(PROG_LEN - 2);
    exec_state_t      state_q, state_d;
    logic [3:0]       ip_q, ip_d;
    logic [REG_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [REG_W-1:0] combo, shr, lit;
    logic             err_q, err_d;
    logic             rsv, fault, is_out, commit;
    logic [4:0]       nip;
    combo_decode #(.W(REG_W)) u_combo (
        .operand_i(bus.operand),
        .a_i      (a_q),
        .b_i      (b_q),
        .c_i      (c_q),
        .value_o  (combo),
        .rsv_o    (rsv)
    );
    assign lit    = REG_W'(bus.operand);
    assign shr    = (combo >= REG_W'(REG_W)) ? '0 : a_q >> combo;
    assign fault  = state_q == EXEC && uses_combo(bus.opcode) && rsv;
    assign is_out = state_q == EXEC && bus.opcode == OP_OUT && !rsv;
    assign commit = state_q == EXEC && !fault && (!is_out || bus.out_ready);
    // next IP is 5 bits wide so running past the program end is detectable
    assign nip    = (bus.opcode == OP_JNZ && a_q != '0) ? {2'b00, bus.operand} : {1'b0, ip_q} + 5'd2;
    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = err_q;
        if ((state_q == IDLE || state_q == HALTED) && bus.start) begin
            state_d = FETCH;
            ip_d    = '0;
            a_d     = bus.a_init;
            b_d     = bus.b_init;
            c_d     = bus.c_init;
            err_d   = 1'b0;
        end else if (state_q == FETCH) begin
            state_d = EXEC;
        end else if (fault) begin
            state_d = HALTED;
            err_d   = 1'b1;
        end else if (commit) begin
            state_d = (nip > LAST_IP) ? HALTED : FETCH;
            ip_d    = nip[3:0];
            a_d     = (bus.opcode == OP_ADV) ? shr : a_q;
            b_d     = (bus.opcode == OP_BXL) ? b_q ^ lit :
                      (bus.opcode == OP_BST) ? REG_W'(combo[2:0]) :
                      (bus.opcode == OP_BXC) ? b_q ^ c_q :
                      (bus.opcode == OP_BDV) ? shr : b_q;
            c_d     = (bus.opcode == OP_CDV) ? shr : c_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ip_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end
    assign bus.instr_ptr = ip_q;
    assign bus.halt      = state_q != FETCH;
    assign bus.out_valid = is_out;
    assign bus.out_data  = is_out ? combo[2:0] : 3'd0;
    assign bus.busy      = state_q == FETCH || state_q == EXEC;
    assign bus.done      = state_q == HALTED;
    assign bus.err       = err_q;
    assign bus.reg_a     = a_q;
    assign bus.reg_b     = b_q;
    assign bus.reg_c     = c_q;
endmodule
